// File: rtl/huffman_pkg.sv
// Shared constants and FSM state encoding for the Huffman decoder and encoder.
package huffman_pkg;

   localparam int NUM_SYM = 6;
   localparam int CODE_W  = 8;
   localparam int LEN_W   = $clog2(CODE_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/huffman_decoder_code_len.sv
// Per-symbol mask analysis: code length (popcount) and legality of the mask shape.
module huff_code_len #(
   parameter int CODE_W = huffman_pkg::CODE_W,
   parameter int LEN_W  = huffman_pkg::LEN_W
) (
   input  logic [CODE_W-1:0] mask_i,
   output logic [LEN_W-1:0]  len_o,
   output logic              legal_o
);
   import huffman_pkg::*;

   logic [CODE_W:0] mask_p1;

   always_comb begin
      len_o = '0;
      for (int i = 0; i < CODE_W; i++) begin
         len_o = len_o + LEN_W'(mask_i[i]);
      end
   end

   // A right-aligned run of ones plus one carries out of the run, leaving no overlap.
   assign mask_p1 = {1'b0, mask_i} + {{CODE_W{1'b0}}, 1'b1};
   assign legal_o = (mask_i != '0) && ((mask_i & mask_p1[CODE_W-1:0]) == '0);

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: loads a codeword/mask table, then matches bits MSB-first.
//  state | meaning
//  IDLE  | no table loaded since reset
//  LOAD  | table registered, lengths and legality being captured
//  RUN   | decoding accepted bits (stalled when the table is illegal)
module huffman_decoder #(
   parameter int NUM_SYM = huffman_pkg::NUM_SYM,
   parameter int CODE_W  = huffman_pkg::CODE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              code_valid,
   input  logic [CODE_W-1:0] HC1,
   input  logic [CODE_W-1:0] HC2,
   input  logic [CODE_W-1:0] HC3,
   input  logic [CODE_W-1:0] HC4,
   input  logic [CODE_W-1:0] HC5,
   input  logic [CODE_W-1:0] HC6,
   input  logic [CODE_W-1:0] M1,
   input  logic [CODE_W-1:0] M2,
   input  logic [CODE_W-1:0] M3,
   input  logic [CODE_W-1:0] M4,
   input  logic [CODE_W-1:0] M5,
   input  logic [CODE_W-1:0] M6,
   input  logic              bit_valid,
   input  logic              bit_in,
   output logic              bit_ready,
   output logic              sym_valid,
   output logic [2:0]        sym,
   output logic              err,
   output logic              table_err,
   output logic [7:0]        sym_count
);
   import huffman_pkg::*;

   localparam int LW = $clog2(CODE_W + 1);
   localparam int NP = 6;

   logic [CODE_W-1:0] hc_in [NP];
   logic [CODE_W-1:0] m_in  [NP];

   state_t            state_q, state_d;
   logic [CODE_W-1:0] hc_q [NUM_SYM];
   logic [CODE_W-1:0] hc_d [NUM_SYM];
   logic [CODE_W-1:0] m_q  [NUM_SYM];
   logic [CODE_W-1:0] m_d  [NUM_SYM];
   logic [LW-1:0]     len_q [NUM_SYM];
   logic [LW-1:0]     len_d [NUM_SYM];
   logic [LW-1:0]     len_w [NUM_SYM];
   logic [NUM_SYM-1:0] legal_w;
   logic [NUM_SYM-1:0] hit;
   logic [CODE_W-1:0] acc_q, acc_d, acc_next;
   logic [LW-1:0]     cnt_q, cnt_d, cnt_p1;
   logic              terr_q, terr_d;
   logic              sym_valid_q, sym_valid_d;
   logic              err_q, err_d;
   logic [2:0]        sym_q, sym_d;
   logic [7:0]        count_q, count_d;
   logic              xfer, hit_any;
   int                hit_idx;

   assign hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
   assign m_in  = '{M1, M2, M3, M4, M5, M6};

   for (genvar k = 0; k < NUM_SYM; k++) begin : g_len
      huff_code_len #(.CODE_W(CODE_W), .LEN_W(LW)) u_len (
         .mask_i  (m_q[k]),
         .len_o   (len_w[k]),
         .legal_o (legal_w[k])
      );
   end

   assign bit_ready = (state_q == RUN) && !terr_q;
   assign xfer      = bit_valid && bit_ready && !code_valid;
   assign acc_next  = {acc_q[CODE_W-2:0], bit_in};
   assign cnt_p1    = cnt_q + LW'(1);

   always_comb begin
      hit     = '0;
      hit_any = 1'b0;
      hit_idx = 0;
      for (int k = 0; k < NUM_SYM; k++) begin
         hit[k] = (cnt_p1 == len_q[k]) && ((acc_next & m_q[k]) == hc_q[k]);
      end
      // Scan downwards so the lowest matching index is the one left standing.
      for (int k = NUM_SYM - 1; k >= 0; k--) begin
         if (hit[k]) begin
            hit_any = 1'b1;
            hit_idx = k;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      hc_d        = hc_q;
      m_d         = m_q;
      len_d       = len_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      terr_d      = terr_q;
      sym_valid_d = 1'b0;
      err_d       = 1'b0;
      sym_d       = sym_q;
      count_d     = count_q;
      case (state_q)
         IDLE: ;
         LOAD: begin
            state_d = RUN;
            len_d   = len_w;
            terr_d  = ~&legal_w;
         end
         RUN: begin
            if (xfer) begin
               if (hit_any) begin
                  sym_valid_d = 1'b1;
                  sym_d       = 3'(hit_idx + 1);
                  count_d     = count_q + 8'd1;
                  acc_d       = '0;
                  cnt_d       = '0;
               end else if (cnt_p1 == LW'(CODE_W)) begin
                  err_d = 1'b1;
                  acc_d = '0;
                  cnt_d = '0;
               end else begin
                  acc_d = acc_next;
                  cnt_d = cnt_p1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (code_valid) begin
         state_d = LOAD;
         for (int k = 0; k < NUM_SYM; k++) begin
            if (k < NP) begin
               hc_d[k] = hc_in[k];
               m_d[k]  = m_in[k];
            end else begin
               hc_d[k] = '0;
               m_d[k]  = '0;
            end
         end
         terr_d  = 1'b0;
         acc_d   = '0;
         cnt_d   = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUM_SYM; k++) begin
            hc_q[k]  <= '0;
            m_q[k]   <= '0;
            len_q[k] <= '0;
         end
         acc_q       <= '0;
         cnt_q       <= '0;
         terr_q      <= 1'b0;
         sym_valid_q <= 1'b0;
         err_q       <= 1'b0;
         sym_q       <= '0;
         count_q     <= '0;
      end else begin
         hc_q        <= hc_d;
         m_q         <= m_d;
         len_q       <= len_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         terr_q      <= terr_d;
         sym_valid_q <= sym_valid_d;
         err_q       <= err_d;
         sym_q       <= sym_d;
         count_q     <= count_d;
      end
   end

   assign sym_valid = sym_valid_q;
   assign err       = err_q;
   assign sym       = sym_q;
   assign table_err = terr_q;
   assign sym_count = count_q;

endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: code_valid  input  1  one-cycle pulse; HC1..HC6/M1..M6 valid and loaded into the table.
REQ-004 SHALL have ports: HC1..HC6  input  8 each  codeword of symbol k, right-aligned, first-transmitted bit at position len-1.
REQ-005 SHALL have ports: M1..M6  input  8 each  mask of symbol k; contiguous right-aligned ones, popcount = code length.
REQ-006 SHALL have port: bit_valid  input  1  bit_in is offered this cycle.
REQ-007 SHALL have port: bit_in  input  1  next serial code bit, MSB of each codeword first.
REQ-008 SHALL have port: bit_ready  output  1  decoder accepts a bit; transfer when bit_valid && bit_ready.
REQ-009 SHALL have port: sym_valid  output  1  one-cycle pulse; sym holds a decoded symbol.
REQ-010 SHALL have port: sym  output  3  decoded symbol index 1..6.
REQ-011 SHALL have port: err  output  1  one-cycle pulse; 8 bits accepted with no match.
REQ-012 SHALL have port: table_err  output  1  level; loaded table has an illegal mask.
REQ-013 SHALL have port: sym_count  output  8  number of symbols decoded since last table load; wraps 255->0.
REQ-014 SHALL have parameters: NUM_SYM, default 6, number of symbols; CODE_W, default 8, maximum code length.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN.
REQ-016 SHALL transition IDLE->LOAD on code_valid, LOAD->RUN after exactly one cycle, and RUN->LOAD on code_valid.
REQ-017 SHALL, in LOAD, register HC/M and compute len_k = popcount(M_k) for each symbol.
REQ-018 SHALL, in LOAD, set table_err when any mask is zero or non-contiguous; table_err holds until the next load or reset.
REQ-019 SHALL drive bit_ready=1 only in RUN with table_err=0.
REQ-020 SHALL, on each accepted bit, update acc = {acc[6:0], bit_in} and cnt = cnt+1.
REQ-021 SHALL match symbol k when (cnt+1) == len_k and ({acc,bit_in} & M_k) == HC_k.
REQ-022 SHALL resolve multiple simultaneous matches (non-prefix-free table) to the lowest k.
REQ-023 SHALL, on a match, assert sym_valid and sym=k in the cycle after the accepting edge, clear acc/cnt, and increment sym_count; latency = 1 cycle.
REQ-024 SHALL, when cnt reaches 8 with no match, pulse err in the next cycle, clear acc/cnt, and leave sym_valid=0.
REQ-025 SHALL keep sym unchanged between pulses.
REQ-026 SHALL, on code_valid during RUN, discard a partial codeword (acc, cnt cleared), clear sym_count, and ignore bit_valid in that cycle.
REQ-027 SHALL give code_valid priority over a simultaneous bit transfer.
REQ-028 SHALL treat a cycle with bit_valid=0 as a stall that preserves acc/cnt.

Reset
REQ-029 SHALL, on reset, set state=IDLE, acc=0, cnt=0, table=0, bit_ready=0, sym_valid=0, sym=0, err=0, table_err=0, sym_count=0.
REQ-030 SHALL, on reset mid-codeword, discard the partial codeword; a table must be reloaded before decoding resumes.

Structure
REQ-031 SHALL place NUM_SYM, CODE_W and the state enum in shared package huffman_pkg, shared with the encoder.
REQ-032 SHALL instantiate one sub-module, huff_code_len, per symbol: 8-bit mask in, 4-bit popcount plus a contiguity-legal flag out.

Verification
Table T: HC1..HC6 = 00,02,06,0E,1E,1F; M1..M6 = 01,03,07,0F,1F,1F (codes 0,10,110,1110,11110,11111).
REQ-033 SHALL test: load T, bits 0 -> sym=1 one cycle later, sym_count=1.
REQ-034 SHALL test: load T, bits 1,1,1,1,1 then 1,1,0 -> sym=6 then sym=3, sym_count=2.
REQ-035 SHALL test: load T with M1=05 -> table_err=1 and bit_ready=0.
REQ-036 SHALL test: table HC all 00 with M all FF, bits 1 x8 -> err pulse, sym_valid=0, cnt cleared.
REQ-037 SHALL test: load T, bits 1,1 then code_valid -> partial discarded; new bits 1,0 -> sym=2.
REQ-038 SHALL test: load T, bit_valid gaps inside 1110 -> sym=4; then reset -> all outputs 0, bit_ready=0.
